// File: rtl/ex_unit_pkg.sv
// Shared RISC-V definitions for the integer execution unit: opcode and funct3
// encodings, op-field slicing and the ALU result record.
package riscv_defs;

    localparam int DATA_W = 32;
    localparam int OP_W   = 10;

    // op_in packs {funct3, opcode}; instr[30] travels in the immediate
    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 7;
    localparam int F3_LSB  = 7;
    localparam int F3_W    = 3;
    localparam int ALT_BIT = 10;

    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

    localparam logic [F3_W-1:0] F3_ADD  = 3'd0;
    localparam logic [F3_W-1:0] F3_SLL  = 3'd1;
    localparam logic [F3_W-1:0] F3_SLT  = 3'd2;
    localparam logic [F3_W-1:0] F3_SLTU = 3'd3;
    localparam logic [F3_W-1:0] F3_XOR  = 3'd4;
    localparam logic [F3_W-1:0] F3_SR   = 3'd5;
    localparam logic [F3_W-1:0] F3_OR   = 3'd6;
    localparam logic [F3_W-1:0] F3_AND  = 3'd7;

    localparam logic [F3_W-1:0] F3_BEQ  = 3'd0;
    localparam logic [F3_W-1:0] F3_BNE  = 3'd1;
    localparam logic [F3_W-1:0] F3_BLT  = 3'd4;
    localparam logic [F3_W-1:0] F3_BGE  = 3'd5;
    localparam logic [F3_W-1:0] F3_BLTU = 3'd6;
    localparam logic [F3_W-1:0] F3_BGEU = 3'd7;

    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic              is_branch;
        logic              taken;
        logic [DATA_W-1:0] target;
    } alu_res_t;

    function automatic logic [OPC_W-1:0] op_opcode(input logic [OP_W-1:0] op);
        return op[OPC_LSB +: OPC_W];
    endfunction

    function automatic logic [F3_W-1:0] op_funct3(input logic [OP_W-1:0] op);
        return op[F3_LSB +: F3_W];
    endfunction

endpackage

// File: rtl/ex_unit_if.sv
// Issue-side and result-bus signals between the reservation station, the
// execution unit and its consumers.
interface ex_unit_if import riscv_defs::*; #(
    parameter int Q_WIDTH = 5
) ();

    logic                in_valid;
    logic [OP_W-1:0]     op_in;
    logic [DATA_W-1:0]   V1_in;
    logic [DATA_W-1:0]   V2_in;
    logic [DATA_W-1:0]   immediate_in;
    logic [DATA_W-1:0]   npc_in;
    logic [Q_WIDTH-1:0]  rob_tag_in;

    logic                update_control;
    logic [Q_WIDTH-1:0]  target_ROB_pos;
    logic [DATA_W-1:0]   V_ex;
    logic                is_branch_out;
    logic                branch_taken_out;
    logic [DATA_W-1:0]   branch_target_out;

    modport master (
        output in_valid, op_in, V1_in, V2_in, immediate_in, npc_in, rob_tag_in,
        input  update_control, target_ROB_pos, V_ex,
               is_branch_out, branch_taken_out, branch_target_out
    );

    modport slave (
        input  in_valid, op_in, V1_in, V2_in, immediate_in, npc_in, rob_tag_in,
        output update_control, target_ROB_pos, V_ex,
               is_branch_out, branch_taken_out, branch_target_out
    );

endinterface

// File: rtl/ex_unit_alu_core.sv
// Combinational integer datapath: ALU ops, LUI/AUIPC, jumps and branch
// resolution for one issued node.
module alu_core import riscv_defs::*; (
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_v1,
    input  logic [DATA_W-1:0] i_v2,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [DATA_W-1:0] i_npc,
    output alu_res_t          o_res
);

    function automatic logic [DATA_W-1:0] int_op(
        input logic [F3_W-1:0]   f3,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic              alt_sub,
        input logic              alt_sra
    );
        logic signed [DATA_W-1:0] a_s;
        logic signed [DATA_W-1:0] b_s;
        logic [4:0]               sh;
        logic [DATA_W-1:0]        r;
        a_s = signed'(a);
        b_s = signed'(b);
        sh  = b[4:0];
        case (f3)
            F3_ADD:  r = alt_sub ? (a - b) : (a + b);
            F3_SLL:  r = a << sh;
            F3_SLT:  r = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            F3_SLTU: r = {{(DATA_W-1){1'b0}}, (a < b)};
            F3_XOR:  r = a ^ b;
            F3_SR:   r = alt_sra ? unsigned'(a_s >>> sh) : (a >> sh);
            F3_OR:   r = a | b;
            F3_AND:  r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic branch_cond(
        input logic [F3_W-1:0]   f3,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] a_s;
        logic signed [DATA_W-1:0] b_s;
        logic                     t;
        a_s = signed'(a);
        b_s = signed'(b);
        case (f3)
            F3_BEQ:  t = (a == b);
            F3_BNE:  t = (a != b);
            F3_BLT:  t = (a_s < b_s);
            F3_BGE:  t = (a_s >= b_s);
            F3_BLTU: t = (a < b);
            F3_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    logic [OPC_W-1:0]  w_opc;
    logic [F3_W-1:0]   w_f3;
    logic              w_alt;
    logic [DATA_W-1:0] w_pc;
    logic [DATA_W-1:0] w_pc_rel;
    logic [DATA_W-1:0] w_jalr_sum;
    logic              w_br_taken;

    assign w_opc      = op_opcode(i_op);
    assign w_f3       = op_funct3(i_op);
    assign w_alt      = i_imm[ALT_BIT];
    assign w_pc       = i_npc - DATA_W'(4);
    assign w_pc_rel   = w_pc + i_imm;
    assign w_jalr_sum = i_v1 + i_imm;
    assign w_br_taken = branch_cond(w_f3, i_v1, i_v2);

    // Immediate forms never subtract; instr[30] only picks SRAI there
    always_comb begin
        o_res = '0;
        case (w_opc)
            OPC_OP_IMM: o_res.value = int_op(w_f3, i_v1, i_imm, 1'b0, w_alt);
            OPC_OP:     o_res.value = int_op(w_f3, i_v1, i_v2, w_alt, w_alt);
            OPC_LUI:    o_res.value = i_imm;
            OPC_AUIPC:  o_res.value = w_pc_rel;
            OPC_JAL: begin
                o_res.value     = i_npc;
                o_res.is_branch = 1'b1;
                o_res.taken     = 1'b1;
                o_res.target    = w_pc_rel;
            end
            OPC_JALR: begin
                o_res.value     = i_npc;
                o_res.is_branch = 1'b1;
                o_res.taken     = 1'b1;
                o_res.target    = {w_jalr_sum[DATA_W-1:1], 1'b0};
            end
            OPC_BRANCH: begin
                o_res.value     = {{(DATA_W-1){1'b0}}, w_br_taken};
                o_res.is_branch = 1'b1;
                o_res.taken     = w_br_taken;
                o_res.target    = w_pc_rel;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ex_unit.sv
// Two-stage integer execution unit: issue latch, combinational ALU, result
// latch driving the execution result bus. Flush and global-ready handled here.
module ex_unit import riscv_defs::*; #(
    parameter int Q_WIDTH = 5
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     clear_in,
    ex_unit_if.slave bus
);

    logic                r_vld_p0;
    logic [OP_W-1:0]     r_op_p0;
    logic [DATA_W-1:0]   r_v1_p0;
    logic [DATA_W-1:0]   r_v2_p0;
    logic [DATA_W-1:0]   r_imm_p0;
    logic [DATA_W-1:0]   r_npc_p0;
    logic [Q_WIDTH-1:0]  r_tag_p0;

    logic                r_vld_p1;
    logic [Q_WIDTH-1:0]  r_tag_p1;
    alu_res_t            r_res_p1;

    alu_res_t            w_res;
    logic                w_adv;

    // rdy_in low freezes everything, including a pending flush
    assign w_adv = rdy_in && !clear_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else if (rdy_in) begin
            r_vld_p0 <= clear_in ? 1'b0 : bus.in_valid;
            r_vld_p1 <= clear_in ? 1'b0 : r_vld_p0;
        end
    end

    // Stage A: issue latch
    always_ff @(posedge clk_in) begin
        if (rdy_in && bus.in_valid) begin
            r_op_p0  <= bus.op_in;
            r_v1_p0  <= bus.V1_in;
            r_v2_p0  <= bus.V2_in;
            r_imm_p0 <= bus.immediate_in;
            r_npc_p0 <= bus.npc_in;
            r_tag_p0 <= bus.rob_tag_in;
        end
    end

    alu_core u_alu (
        .i_op  (r_op_p0),
        .i_v1  (r_v1_p0),
        .i_v2  (r_v2_p0),
        .i_imm (r_imm_p0),
        .i_npc (r_npc_p0),
        .o_res (w_res)
    );

    // Stage B: result latch, loaded only for live nodes
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_tag_p1 <= '0;
            r_res_p1 <= '0;
        end else if (w_adv && r_vld_p0) begin
            r_tag_p1 <= r_tag_p0;
            r_res_p1 <= w_res;
        end
    end

    assign bus.update_control    = r_vld_p1;
    assign bus.target_ROB_pos    = r_tag_p1;
    assign bus.V_ex              = r_res_p1.value;
    assign bus.is_branch_out     = r_res_p1.is_branch;
    assign bus.branch_taken_out  = r_res_p1.taken;
    assign bus.branch_target_out = r_res_p1.target;

endmodule

// File: doc/ex_unit.md
# ex_unit

Integer execution unit sitting directly downstream of the reservation station. It accepts one issued node per cycle (op, operands, immediate, npc, ROB tag) and computes ALU, branch and jump results in a two-stage pipeline. It broadcasts the result on the execution result bus (`update_control`/`target_ROB_pos`/`V_ex`), which feeds back into the reservation station, SLBuffer and ROB, and reports branch/jump outcomes to the ROB. Loads and stores never enter this block.

## Interface
- `Q_WIDTH`, 5: ROB tag width. Tag 0 means "no dependency" and is never a valid node tag.
- `clk_in` input 1: clock, all state on rising edge.
- `rst_in` input 1: reset, asynchronous, active-low.
- `rdy_in` input 1: global ready. Low freezes all state.
- `clear_in` input 1: ROB misprediction flush. Kills all in-flight nodes.
- `in_valid` input 1: node present this cycle (RS `has_ex_node`).
- `op_in` input 10: `{funct3[2:0], opcode[6:0]}`.
- `V1_in`, `V2_in` input 32: source operand values.
- `immediate_in` input 32: sign-extended immediate. For R-type, `immediate_in[10]` carries instr[30], which selects SUB/SRA.
- `npc_in` input 32: instruction pc + 4.
- `rob_tag_in` input Q_WIDTH: destination ROB entry.
- `update_control` output 1: result broadcast valid. Reset 0.
- `target_ROB_pos` output Q_WIDTH: tag of the broadcast node. Reset 0.
- `V_ex` output 32: result value. Reset 0.
- `is_branch_out` output 1: node is a branch, JAL or JALR. Reset 0.
- `branch_taken_out` output 1: control transfer taken. Reset 0.
- `branch_target_out` output 32: taken target address. Reset 0.

## Operation
- **Stage A (issue latch):** on an edge with `rdy_in`=1, capture `in_valid` and all inputs into A registers. Input fields are ignored when `in_valid`=0.
- **Stage B (result latch):** on the same edge, compute from the A registers via the ALU and latch into output registers. `update_control` equals A.valid.
- **pc** = npc − 4 (32-bit wraparound).
- **OP-IMM:** ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI (chosen by imm[10]). Shift amount = imm[4:0].
- **OP:** ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. Shift amount = V2[4:0].
- **LUI:** V_ex = imm. **AUIPC:** V_ex = pc + imm.
- **JAL:** V_ex = npc, taken = 1, target = pc + imm.
- **JALR:** V_ex = npc, taken = 1, target = (V1 + imm) & ~1.
- **BRANCH:** BEQ, BNE, BLT, BGE (signed), BLTU, BGEU (unsigned). V_ex = {31'b0, taken}, target = pc + imm whether or not taken.
- `is_branch_out` = 1 only for BRANCH, JAL and JALR.
- Unknown opcode: broadcast with V_ex = 0, is_branch_out = 0.
- All arithmetic is modulo 2^32. Overflow is ignored.
- Every accepted node produces exactly one broadcast, unless it is flushed.
- **Flush:** `clear_in`=1 at an edge with `rdy_in`=1 sets both A.valid and B valid to 0, and the new `in_valid` is discarded. Data registers may keep stale values.
- `rdy_in`=0 overrides `clear_in`, and nothing changes.

## Timing
- **Latency:** a node presented at edge E is visible on the outputs after edge E+1, for exactly one cycle when the next slot is empty.
- **Throughput:** 1 node/cycle, with no backpressure. This block never stalls the RS.
- **rdy_in low for k cycles:** outputs hold, including a held `update_control`=1. Consumers must also be gated by `rdy_in`, so a held broadcast is never double-counted.
- **Async reset:** asserting `rst_in` mid-operation clears all valids and outputs to their reset values immediately. The first node is accepted at the first rising edge after deassertion.
- **Back-to-back dependent nodes:** no internal forwarding. Dependents wake up in the RS through the broadcast.

## Structure
- The shared package `riscv_defs` holds:
  - opcode constants (OP_IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH);
  - funct3 constants;
  - the `op` field slicing positions.
- Sub-module `alu_core`: purely combinational. It maps (op, V1, V2, imm, npc) to (value, is_branch, taken, target) and sits between the stage-A and stage-B registers.
- The top level contains only the two register stages, the valid/flush logic and the `rdy_in` gating.

## Test plan
- **ADD:** ADD V1=7, V2=5, tag 3 at edge E → after E+1: update_control=1, target_ROB_pos=3, V_ex=12. The next cycle, update_control=0.
- **SUB/SRA:** SUB (imm[10]=1) with V1=5, V2=7 → V_ex=0xFFFFFFFE. SRA V1=0x80000000, V2=4 → 0xF8000000.
- **Branches:** BLT V1=0xFFFFFFFF, V2=1, npc=0x104, imm=0x20 → taken=1, target=0x120. The same inputs as BLTU → taken=0, target=0x120.
- **JALR:** V1=0x1001, imm=2, npc=0x50 → V_ex=0x50, taken=1, target=0x1002.
- **Flush and stall:** three back-to-back nodes with clear_in pulsed at the edge after the second → only the first is broadcast. Dropping rdy_in for 3 cycles while a result is on the outputs holds those outputs unchanged.
- **Reset mid-stream:** assert rst_in asynchronously between edges while nodes are in flight → all outputs read 0 before the next edge. After deassertion, a new node appears 2 edges later.
